// File: rtl/cr_huf_comp_sa_lut_rd_pkg.sv
// Package for the long-symbol LUT read sequencer.
// Holds the default parameter values, the FSM state encoding, the out_kind
// encodings, the side-pipe and FIFO entry layouts, and a helper that places a
// header word on lane 0 of a four-lane data bus.
package cr_huf_comp_sa_lut_rd_pkg;

  localparam int DEF_HDR_W       = 27;
  localparam int DEF_SYM_ADDR_W  = 9;
  localparam int DEF_STCL_ADDR_W = 5;
  localparam int DEF_ST_ADDR_W   = 9;
  localparam int DEF_SEQID_W     = 3;
  localparam int DEF_SIZE_W      = 16;
  localparam int DEF_RD_LAT      = 2;
  localparam int DEF_FIFO_DEPTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VLD,
    ST_RD_STCL,
    ST_RD_ST,
    ST_DATA,
    ST_DRAIN,
    ST_ACK
  } state_e;

  typedef enum logic [1:0] {
    KIND_STCL = 2'd0,
    KIND_ST   = 2'd1,
    KIND_DATA = 2'd2
  } kind_e;

  // Per-read tag that travels alongside the LUT latency.
  typedef struct packed {
    kind_e      kind;
    logic [2:0] cnt;
    logic       last;
  } side_t;

  typedef struct packed {
    kind_e                      kind;
    logic [2:0]                 cnt;
    logic                       last;
    logic [4*DEF_HDR_W-1:0]     data;
  } fifo_entry_t;

  // Header words occupy lane 0; the other lanes read as zero.
  function automatic logic [4*DEF_HDR_W-1:0] hdr_to_lanes(input logic [DEF_HDR_W-1:0] w);
    return {{(3*DEF_HDR_W){1'b0}}, w};
  endfunction

endpackage

// File: rtl/cr_huf_comp_sa_lut_rd_fifo.sv
// Synchronous FIFO with occupancy count and fall-through head.
// Ports: clk, rst (sync, active high), push/push_data, pop,
//        head_data (valid when !empty), empty, count (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module cr_huf_comp_sa_lut_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  // A push into a full FIFO is only taken when a pop frees the slot.
  assign do_push   = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_sa_lut_rd.sv
// Long-symbol LUT read sequencer.
// Per job: wait for LUT header/table validity, read the stcl then st header
// words, then translate the 4-lane symbol address stream into LUT data reads.
// Returned words are buffered in a credit-protected FIFO and presented on the
// out_* interface; sa_ret_ack pulses once the job has fully drained.
// Ports: clk/rst; job_start/job_seq_id; lut_* validity, sizes and returns;
//        sa_* read strobes/addresses, ret_ack, seq_id; sym_* input stream;
//        out_* output stream.
// Optional: define CR_HUF_COMP_SA_LUT_RD_STATS_EN to add stat_rd_cnt,
//           stat_stall_cnt and stat_err.
module cr_huf_comp_sa_lut_rd
  import cr_huf_comp_sa_lut_rd_pkg::*;
#(
  parameter int HDR_W       = DEF_HDR_W,
  parameter int SYM_ADDR_W  = DEF_SYM_ADDR_W,
  parameter int STCL_ADDR_W = DEF_STCL_ADDR_W,
  parameter int ST_ADDR_W   = DEF_ST_ADDR_W,
  parameter int SEQID_W     = DEF_SEQID_W,
  parameter int SIZE_W      = DEF_SIZE_W,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_start,
  input  logic [SEQID_W-1:0]      job_seq_id,
  input  logic                    lut_st_vld,
  input  logic                    lut_hw_vld,
  input  logic [SIZE_W-1:0]       lut_stcl_size,
  input  logic [SIZE_W-1:0]       lut_st_size,
  input  logic                    lut_st_stcl_val,
  input  logic [HDR_W-1:0]        lut_st_stcl_rd_data,
  input  logic                    lut_data_val,
  input  logic [4*HDR_W-1:0]      lut_rd_data,
  output logic                    sa_ret_stcl_rd,
  output logic [STCL_ADDR_W-1:0]  sa_ret_stcl_addr,
  output logic                    sa_ret_st_rd,
  output logic [ST_ADDR_W-1:0]    sa_ret_st_addr,
  output logic                    sa_data_rd,
  output logic [4*SYM_ADDR_W-1:0] sa_data_addr,
  output logic                    sa_ret_ack,
  output logic [SEQID_W-1:0]      sa_seq_id,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [4*SYM_ADDR_W-1:0] sym_addr,
  input  logic [2:0]              sym_cnt,
  input  logic                    sym_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_kind,
  output logic [2:0]              out_cnt,
  output logic [4*HDR_W-1:0]      out_data,
  output logic                    out_last
`ifdef CR_HUF_COMP_SA_LUT_RD_STATS_EN
  ,
  output logic [31:0]             stat_rd_cnt,
  output logic [31:0]             stat_stall_cnt,
  output logic                    stat_err
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q;
  logic [SEQID_W-1:0]   seq_id_q;
  logic [SIZE_W-1:0]    stcl_size_q;
  logic [SIZE_W-1:0]    st_size_q;
  logic [SIZE_W:0]      bits_q;
  logic [ST_ADDR_W-1:0] hdr_addr_q;
  logic [CW-1:0]        inflight_q;
  side_t                pipe_q [RD_LAT];

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fifo_entry_t   push_entry;
  fifo_entry_t   head_entry;
  side_t         side_in;
  logic credit, stcl_more, st_more;
  logic issue_stcl, issue_st, accept, issue;
  logic ret_any, ret_ok, orphan;

  // Outstanding reads plus buffered words may never exceed the FIFO depth,
  // so every return always has a slot.
  assign credit     = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign stcl_more  = bits_q < {1'b0, stcl_size_q};
  assign st_more    = bits_q < {1'b0, st_size_q};
  assign issue_stcl = (state_q == ST_RD_STCL) & stcl_more & credit;
  assign issue_st   = (state_q == ST_RD_ST) & st_more & credit;
  assign sym_ready  = (state_q == ST_DATA) & credit;
  assign accept     = sym_valid & sym_ready;
  assign issue      = issue_stcl | issue_st | accept;
  assign ret_any    = lut_st_stcl_val | lut_data_val;
  assign ret_ok     = ret_any & (inflight_q != '0);
  assign orphan     = ret_any & (inflight_q == '0);

  assign sa_ret_stcl_rd   = issue_stcl;
  assign sa_ret_stcl_addr = hdr_addr_q[STCL_ADDR_W-1:0];
  assign sa_ret_st_rd     = issue_st;
  assign sa_ret_st_addr   = hdr_addr_q;
  assign sa_data_rd       = accept;
  assign sa_data_addr     = sym_addr;
  assign sa_ret_ack       = (state_q == ST_ACK);
  assign sa_seq_id        = seq_id_q;

  always_comb begin
    side_in      = '0;
    side_in.kind = issue_stcl ? KIND_STCL : (issue_st ? KIND_ST : KIND_DATA);
    // Header words carry a single lane.
    side_in.cnt  = accept ? sym_cnt : 3'd1;
    side_in.last = accept & sym_last;
  end

  // Tag pipe: the oldest stage lines up with the return strobe RD_LAT later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue ? side_in : '0;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.kind = pipe_q[RD_LAT-1].kind;
    push_entry.cnt  = pipe_q[RD_LAT-1].cnt;
    push_entry.last = pipe_q[RD_LAT-1].last;
    push_entry.data = lut_data_val ? lut_rd_data : hdr_to_lanes(lut_st_stcl_rd_data);
  end

  cr_huf_comp_sa_lut_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_ok),
    .push_data (push_entry),
    .pop       (out_ready),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_kind  = head_entry.kind;
  assign out_cnt   = head_entry.cnt;
  assign out_last  = head_entry.last;
  assign out_data  = head_entry.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seq_id_q    <= '0;
      stcl_size_q <= '0;
      st_size_q   <= '0;
      bits_q      <= '0;
      hdr_addr_q  <= '0;
      inflight_q  <= '0;
    end else begin
      unique case ({issue, ret_ok})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase

      unique case (state_q)
        ST_IDLE: begin
          if (job_start) begin
            seq_id_q <= job_seq_id;
            state_q  <= ST_WAIT_VLD;
          end
        end
        ST_WAIT_VLD: begin
          if (lut_st_vld & lut_hw_vld) begin
            stcl_size_q <= lut_stcl_size;
            st_size_q   <= lut_st_size;
            bits_q      <= '0;
            hdr_addr_q  <= '0;
            // Empty regions are skipped outright so no dead cycles are spent.
            if (lut_stcl_size != '0)    state_q <= ST_RD_STCL;
            else if (lut_st_size != '0) state_q <= ST_RD_ST;
            else                        state_q <= ST_DATA;
          end
        end
        ST_RD_STCL: begin
          if (issue_stcl) begin
            bits_q     <= bits_q + (SIZE_W+1)'(HDR_W);
            hdr_addr_q <= hdr_addr_q + 1'b1;
          end else if (!stcl_more) begin
            bits_q     <= '0;
            hdr_addr_q <= '0;
            state_q    <= (st_size_q != '0) ? ST_RD_ST : ST_DATA;
          end
        end
        ST_RD_ST: begin
          if (issue_st) begin
            bits_q     <= bits_q + (SIZE_W+1)'(HDR_W);
            hdr_addr_q <= hdr_addr_q + 1'b1;
          end else if (!st_more) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept & sym_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((inflight_q == '0) & fifo_empty) state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CR_HUF_COMP_SA_LUT_RD_STATS_EN
  logic [31:0] stat_rd_cnt_q;
  logic [31:0] stat_stall_cnt_q;
  logic        stat_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt_q    <= '0;
      stat_stall_cnt_q <= '0;
      stat_err_q       <= 1'b0;
    end else begin
      if (issue & (stat_rd_cnt_q != '1)) stat_rd_cnt_q <= stat_rd_cnt_q + 32'd1;
      if ((state_q == ST_DATA) & sym_valid & ~sym_ready & (stat_stall_cnt_q != '1))
        stat_stall_cnt_q <= stat_stall_cnt_q + 32'd1;
      if (orphan) stat_err_q <= 1'b1;
    end
  end

  assign stat_rd_cnt    = stat_rd_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
  assign stat_err       = stat_err_q;
`else
  // Orphan returns are simply dropped when statistics are not built in.
  logic unused_orphan;
  assign unused_orphan = orphan;
`endif

endmodule

// File: tb/tb_cr_huf_comp_sa_lut_rd.sv
// Testbench for cr_huf_comp_sa_lut_rd: fixed-latency LUT model, expected-output
// queue filled as stimulus is driven and drained as the DUT emits words.
module tb_cr_huf_comp_sa_lut_rd;

  localparam int HDR_W  = 27;
  localparam int SAW    = 9;
  localparam int RD_LAT = 2;

  logic clk;
  logic rst;
  logic job_start;
  logic [2:0] job_seq_id;
  logic lut_st_vld, lut_hw_vld;
  logic [15:0] lut_stcl_size, lut_st_size;
  logic lut_st_stcl_val;
  logic [HDR_W-1:0] lut_st_stcl_rd_data;
  logic lut_data_val;
  logic [4*HDR_W-1:0] lut_rd_data;
  logic sa_ret_stcl_rd;
  logic [4:0] sa_ret_stcl_addr;
  logic sa_ret_st_rd;
  logic [8:0] sa_ret_st_addr;
  logic sa_data_rd;
  logic [4*SAW-1:0] sa_data_addr;
  logic sa_ret_ack;
  logic [2:0] sa_seq_id;
  logic sym_valid, sym_ready;
  logic [4*SAW-1:0] sym_addr;
  logic [2:0] sym_cnt;
  logic sym_last;
  logic out_valid, out_ready;
  logic [1:0] out_kind;
  logic [2:0] out_cnt;
  logic [4*HDR_W-1:0] out_data;
  logic out_last;
`ifdef CR_HUF_COMP_SA_LUT_RD_STATS_EN
  logic [31:0] stat_rd_cnt, stat_stall_cnt;
  logic stat_err;
`endif

  cr_huf_comp_sa_lut_rd dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_seq_id(job_seq_id),
    .lut_st_vld(lut_st_vld), .lut_hw_vld(lut_hw_vld),
    .lut_stcl_size(lut_stcl_size), .lut_st_size(lut_st_size),
    .lut_st_stcl_val(lut_st_stcl_val), .lut_st_stcl_rd_data(lut_st_stcl_rd_data),
    .lut_data_val(lut_data_val), .lut_rd_data(lut_rd_data),
    .sa_ret_stcl_rd(sa_ret_stcl_rd), .sa_ret_stcl_addr(sa_ret_stcl_addr),
    .sa_ret_st_rd(sa_ret_st_rd), .sa_ret_st_addr(sa_ret_st_addr),
    .sa_data_rd(sa_data_rd), .sa_data_addr(sa_data_addr),
    .sa_ret_ack(sa_ret_ack), .sa_seq_id(sa_seq_id),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_addr(sym_addr),
    .sym_cnt(sym_cnt), .sym_last(sym_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_cnt(out_cnt), .out_data(out_data), .out_last(out_last)
`ifdef CR_HUF_COMP_SA_LUT_RD_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt), .stat_err(stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]         kind;
    logic [2:0]         cnt;
    logic               last;
    logic [4*HDR_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  logic [8:0] stcl_log[$];
  logic [8:0] st_log[$];
  int ack_cnt = 0;
  logic [2:0] ack_seq = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HDR_W-1:0] stcl_word(input logic [8:0] a);
    return 27'h5A00000 ^ {18'h0, a};
  endfunction

  function automatic logic [HDR_W-1:0] st_word(input logic [8:0] a);
    return 27'h2C00000 ^ {18'h0, a};
  endfunction

  function automatic logic [4*HDR_W-1:0] lane_words(input logic [4*SAW-1:0] av);
    logic [4*HDR_W-1:0] r;
    logic [8:0] a;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = av[i*SAW +: SAW];
      r[i*HDR_W +: HDR_W] = {a, ~a, a};
    end
    return r;
  endfunction

  // LUT model: fixed RD_LAT read-to-valid latency for both ports.
  logic [RD_LAT-1:0]  d_vld_p, h_vld_p;
  logic [4*HDR_W-1:0] d_dat_p [RD_LAT];
  logic [HDR_W-1:0]   h_dat_p [RD_LAT];

  always @(posedge clk) begin
    d_vld_p[0] <= sa_data_rd;
    d_dat_p[0] <= lane_words(sa_data_addr);
    h_vld_p[0] <= sa_ret_stcl_rd | sa_ret_st_rd;
    h_dat_p[0] <= sa_ret_stcl_rd ? stcl_word({4'h0, sa_ret_stcl_addr}) : st_word(sa_ret_st_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      d_vld_p[i] <= d_vld_p[i-1];
      d_dat_p[i] <= d_dat_p[i-1];
      h_vld_p[i] <= h_vld_p[i-1];
      h_dat_p[i] <= h_dat_p[i-1];
    end
  end

  assign lut_data_val        = d_vld_p[RD_LAT-1];
  assign lut_rd_data         = d_dat_p[RD_LAT-1];
  assign lut_st_stcl_val     = h_vld_p[RD_LAT-1];
  assign lut_st_stcl_rd_data = h_dat_p[RD_LAT-1];

  // Output monitor and read/ack logging, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sa_ret_stcl_rd) stcl_log.push_back({4'h0, sa_ret_stcl_addr});
    if (sa_ret_st_rd)   st_log.push_back(sa_ret_st_addr);
    if (sa_ret_ack) begin
      ack_cnt++;
      ack_seq = sa_seq_id;
    end
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_kind", 128'(out_kind), 128'(e.kind));
        check("out_cnt",  128'(out_cnt),  128'(e.cnt));
        check("out_last", 128'(out_last), 128'(e.last));
        check("out_data", 128'(out_data), 128'(e.data));
        $display("out kind=%0d cnt=%0d last=%0d data=%h", out_kind, out_cnt, out_last, out_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [1:0] kind, input logic [HDR_W-1:0] w);
    exp_t e;
    e.kind = kind; e.cnt = 3'd1; e.last = 1'b0; e.data = {{(3*HDR_W){1'b0}}, w};
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [4*SAW-1:0] a, input logic [2:0] c, input logic l);
    exp_t e;
    logic done;
    done = 1'b0;
    sym_valid = 1'b1; sym_addr = a; sym_cnt = c; sym_last = l;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sym_ready) begin
        e.kind = 2'd2; e.cnt = c; e.last = l; e.data = lane_words(a);
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    sym_valid = 1'b0;
    check("beat_accepted", 128'(done), 128'd1);
  endtask

  task automatic start_job(input logic [2:0] id);
    job_start = 1'b1; job_seq_id = id;
    tick();
    job_start = 1'b0;
  endtask

  task automatic wait_ack(input int target, input logic [2:0] id);
    for (int i = 0; i < 300 && ack_cnt < target; i++) tick();
    tick(); tick();
    check("ack_count", 128'(ack_cnt), 128'(target));
    check("ack_seq_id", 128'(ack_seq), 128'(id));
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("job %0d released, acks=%0d", id, ack_cnt);
  endtask

  initial begin
    logic seen;
    int acc;
    rst = 1'b1; job_start = 1'b0; job_seq_id = '0;
    lut_st_vld = 1'b0; lut_hw_vld = 1'b0; lut_stcl_size = '0; lut_st_size = '0;
    sym_valid = 1'b0; sym_addr = '0; sym_cnt = '0; sym_last = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_sym_ready", 128'(sym_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_ack", 128'(sa_ret_ack), 128'd0);
    check("rst_seq_id", 128'(sa_seq_id), 128'd0);
    check("rst_strobes", 128'({sa_ret_stcl_rd, sa_ret_st_rd, sa_data_rd}), 128'd0);
    rst = 1'b0;
    tick();

    // Job 5: two stcl words, one st word, three data beats.
    start_job(3'd5);
    check("seq_latched", 128'(sa_seq_id), 128'd5);
    push_hdr(2'd0, stcl_word(9'd0));
    push_hdr(2'd0, stcl_word(9'd1));
    push_hdr(2'd1, st_word(9'd0));
    lut_stcl_size = 16'd54; lut_st_size = 16'd27; lut_st_vld = 1'b1; lut_hw_vld = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (sa_ret_st_rd) seen = 1'b1;
    end
    check("st_rd_seen", 128'(seen), 128'd1);
    // Start request while reading st headers must be ignored.
    start_job(3'd3);
    check("seq_kept_in_rd_st", 128'(sa_seq_id), 128'd5);
    lut_st_vld = 1'b0; lut_hw_vld = 1'b0;
    send_beat(36'h123456789, 3'd4, 1'b0);
    send_beat(36'h0FEDCBA98, 3'd4, 1'b0);
    send_beat(36'h055AA33CC, 3'd2, 1'b1);
    wait_ack(1, 3'd5);
    check("stcl_rd_count", 128'(stcl_log.size()), 128'd2);
    if (stcl_log.size() >= 2) begin
      check("stcl_addr0", 128'(stcl_log[0]), 128'd0);
      check("stcl_addr1", 128'(stcl_log[1]), 128'd1);
    end
    check("st_rd_count", 128'(st_log.size()), 128'd1);
    if (st_log.size() >= 1) check("st_addr0", 128'(st_log[0]), 128'd0);

    // Job 2: empty header regions go straight to DATA.
    stcl_log.delete(); st_log.delete();
    start_job(3'd2);
    check("wait_vld_not_ready", 128'(sym_ready), 128'd0);
    lut_stcl_size = 16'd0; lut_st_size = 16'd0; lut_st_vld = 1'b1; lut_hw_vld = 1'b1;
    tick();
    check("data_one_cycle_after_vld", 128'(sym_ready), 128'd1);
    lut_st_vld = 1'b0; lut_hw_vld = 1'b0;
    send_beat(36'h000000001, 3'd1, 1'b1);
    wait_ack(2, 3'd2);
    check("no_hdr_reads", 128'(stcl_log.size() + st_log.size()), 128'd0);

    // Job 6: back-pressure fills the credit window.
    out_ready = 1'b0;
    start_job(3'd6);
    lut_st_vld = 1'b1; lut_hw_vld = 1'b1;
    tick();
    lut_st_vld = 1'b0; lut_hw_vld = 1'b0;
    acc = 0;
    sym_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sym_addr = 36'(i * 32'h01234567 + 32'h89AB);
      sym_cnt = 3'd3; sym_last = 1'b0;
      if (sym_ready) begin
        exp_t e;
        e.kind = 2'd2; e.cnt = 3'd3; e.last = 1'b0; e.data = lane_words(sym_addr);
        sb.push_back(e);
        acc++;
      end
      tick();
    end
    sym_valid = 1'b0;
    $display("backpressure accepted %0d beats", acc);
    check("credit_accepts", 128'(acc), 128'd8);
    check("credit_blocked", 128'(sym_ready), 128'd0);
    check("fifo_holding", 128'(out_valid), 128'd1);
    out_ready = 1'b1;
    check("blocked_before_pop", 128'(sym_ready), 128'd0);
    tick();
    out_ready = 1'b0;
    check("ready_after_pop", 128'(sym_ready), 128'd1);
    out_ready = 1'b1;
    send_beat(36'h0ABCDEF01, 3'd4, 1'b1);
    wait_ack(3, 3'd6);

    // Job 7: reset in the middle of DATA with reads outstanding.
    out_ready = 1'b0;
    start_job(3'd7);
    lut_st_vld = 1'b1; lut_hw_vld = 1'b1;
    tick();
    lut_st_vld = 1'b0; lut_hw_vld = 1'b0;
    send_beat(36'h111111111, 3'd4, 1'b0);
    send_beat(36'h222222222, 3'd4, 1'b0);
    send_beat(36'h333333333, 3'd4, 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_sym_ready", 128'(sym_ready), 128'd0);
    check("midrst_seq_id", 128'(sa_seq_id), 128'd0);
    check("midrst_strobes", 128'({sa_ret_stcl_rd, sa_ret_st_rd, sa_data_rd, sa_ret_ack}), 128'd0);
    repeat (4) tick();
    check("late_return_dropped", 128'(out_valid), 128'd0);
    check("no_ack_after_rst", 128'(ack_cnt), 128'd3);
`ifdef CR_HUF_COMP_SA_LUT_RD_STATS_EN
    check("stat_err_orphan", 128'(stat_err), 128'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_huf_comp_sa_lut_rd.md
Name: cr_huf_comp_sa_lut_rd

Overview:
Read sequencer for the long-symbol LUT pair; consumer of the combined LUT return interface. Per job it waits for LUT header/table validity, streams the stored stcl and st header words out, then translates a 4-lane symbol address stream into LUT data reads. It buffers returned code words in a credit-protected FIFO for the downstream bit packer and pulses ret_ack once the job drains.

Parameters:
HDR_W, 27, LUT header/code word width
SYM_ADDR_W, 9, symbol address width per lane
STCL_ADDR_W, 5, stcl read address width
ST_ADDR_W, 9, st read address width
SEQID_W, 3, job sequence id width
SIZE_W, 16, bit-size field width (stcl/st sizes)
RD_LAT, 2, fixed LUT read-to-valid latency in cycles
FIFO_DEPTH, 8, return buffer entries (power of 2, >= RD_LAT+2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_start  in  1  start pulse, accepted only in IDLE
job_seq_id  in  SEQID_W  id of job being started
lut_st_vld  in  1  LUT header sizes valid
lut_hw_vld  in  1  LUT data table valid
lut_stcl_size  in  SIZE_W  stcl region size in bits
lut_st_size  in  SIZE_W  st region size in bits
lut_st_stcl_val  in  1  header read return strobe
lut_st_stcl_rd_data  in  HDR_W  header read return data
lut_data_val  in  1  data read return strobe
lut_rd_data  in  4*HDR_W  lane 0..3 returned code words
sa_ret_stcl_rd  out  1  stcl read strobe
sa_ret_stcl_addr  out  STCL_ADDR_W  stcl read address
sa_ret_st_rd  out  1  st read strobe
sa_ret_st_addr  out  ST_ADDR_W  st read address
sa_data_rd  out  1  data read strobe
sa_data_addr  out  4*SYM_ADDR_W  lane 0..3 addresses
sa_ret_ack  out  1  one-cycle job release
sa_seq_id  out  SEQID_W  id of current job
sym_valid  in  1  symbol beat valid
sym_ready  out  1  symbol beat accepted
sym_addr  in  4*SYM_ADDR_W  lane addresses
sym_cnt  in  3  valid lanes 1..4
sym_last  in  1  last beat of job
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_kind  out  2  0=stcl,1=st,2=data
out_cnt  out  3  valid lanes
out_data  out  4*HDR_W  lane words (header uses lane 0)
out_last  out  1  last data beat of job

Behaviour:
- Reset: FSM IDLE; all strobes, sym_ready, out_valid, sa_ret_ack 0; addresses, sa_seq_id, counters, FIFO pointers 0.
- States: IDLE -> WAIT_VLD on job_start (latch seq_id). WAIT_VLD -> RD_STCL when lut_st_vld & lut_hw_vld (latch sizes). RD_STCL -> RD_ST when bits_issued >= stcl_size. RD_ST -> DATA when bits_issued >= st_size. DATA -> DRAIN on accepted sym_last. DRAIN -> ACK when inflight==0 and FIFO empty. ACK (1 cycle, sa_ret_ack=1) -> IDLE.
- Header reads: address starts at 0, +1 per read; bits_issued starts 0, +HDR_W per read; zero size skips the state with no reads.
- Credit: issue allowed only if fifo_count + inflight < FIFO_DEPTH. inflight +1 on issue, -1 on return strobe; simultaneous issue and return leaves it unchanged.
- DATA: sym_ready = (state==DATA) & credit; accept issues sa_data_rd same cycle with sym_addr; sym_cnt/sym_last travel through RD_LAT-deep side pipe and are paired with lut_data_val.
- Return strobes push one FIFO entry; the two return strobes are never concurrent. A strobe with inflight==0 is ignored and flagged in the stats error sticky bit.
- FIFO: out_valid = !empty; pop on out_valid & out_ready; push and pop in the same cycle keeps count; pointers wrap modulo FIFO_DEPTH.
- job_start outside IDLE ignored. rst mid-job flushes FIFO, inflight and pipe immediately; no ret_ack is issued.

Optional Feature:
CR_HUF_COMP_SA_LUT_RD_STATS_EN: adds outputs stat_rd_cnt (32b, reads issued), stat_stall_cnt (32b, cycles with sym_valid & !sym_ready in DATA), stat_err (sticky orphan-return). All cleared by rst and saturating. Without the macro these ports and their logic are absent.

Decomposition:
- Package cr_huf_comp_sa_lut_rdPKG: state enum, out_kind encodings (KIND_STCL/ST/DATA), FIFO entry struct {kind,cnt,last,data}.
- One sub-module cr_huf_comp_sa_lut_rd_fifo: synchronous FIFO with count output, parameterized on depth and entry width.

Test Plan:
- stcl_size=54, st_size=27, both vld -> 2 stcl reads (addr 0,1) then 1 st read (addr 0); out_kind 0,0,1 in order.
- stcl_size=0, st_size=0 -> no header reads; DATA is entered 1 cycle after vld.
- 3 data beats (cnt 4,4,2, last on 3rd), out_ready=1 -> 3 data outputs RD_LAT cycles later; out_last on 3rd; sa_ret_ack pulses once with latched seq_id=5.
- out_ready=0, FIFO_DEPTH=8 -> sym_ready drops once count+inflight==8; no overflow; sym_ready resumes 1 cycle after the first pop.
- rst asserted during DATA with 3 in flight -> next cycle all outputs at reset values; late lut_data_val is ignored and stat_err=1 when stats are enabled.
- job_start while in RD_ST -> ignored; seq_id unchanged.
